// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse position pipeline: packet field
// positions, status bit indices, FSM state encoding and delta extraction.
package ps2_mouse_pkg;

    localparam int unsigned ST_L   = 0;
    localparam int unsigned ST_R   = 1;
    localparam int unsigned ST_M   = 2;
    localparam int unsigned ST_ONE = 3;
    localparam int unsigned ST_XS  = 4;
    localparam int unsigned ST_YS  = 5;
    localparam int unsigned ST_XO  = 6;
    localparam int unsigned ST_YO  = 7;

    localparam int unsigned FIELD_STATUS_LSB = 0;
    localparam int unsigned FIELD_X_LSB      = 8;
    localparam int unsigned FIELD_Y_LSB      = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ADD_X = 3'd2,
        ADD_Y = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Overflowed axes contribute no movement.
    function automatic logic signed [8:0] x_delta(input logic [23:0] pkt);
        return pkt[ST_XO] ? 9'sd0 : $signed({pkt[ST_XS], pkt[FIELD_X_LSB +: 8]});
    endfunction

    function automatic logic signed [8:0] y_delta(input logic [23:0] pkt);
        return pkt[ST_YO] ? 9'sd0 : $signed({pkt[ST_YS], pkt[FIELD_Y_LSB +: 8]});
    endfunction

endpackage

// File: rtl/ps2_axis_clamp.sv
// Combinational single-axis update: position +/- signed delta, clamped to [0, max_i].
module ps2_axis_clamp #(
    parameter bit SUBTRACT = 1'b0
) (
    input  logic              [9:0] pos_i,
    input  logic signed       [8:0] delta_i,
    input  logic              [9:0] max_i,
    output logic              [9:0] pos_o
);

    logic signed [11:0] delta_ext;
    logic signed [11:0] pos_ext;
    logic signed [11:0] max_ext;
    logic signed [11:0] sum;

    // One guard bit beyond 11 so a 10-bit position plus a full delta cannot wrap.
    always_comb begin
        delta_ext = {{3{delta_i[8]}}, delta_i};
        pos_ext   = $signed({2'b00, pos_i});
        max_ext   = $signed({2'b00, max_i});
        sum       = SUBTRACT ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
        if (sum < 12'sd0) begin
            pos_o = '0;
        end else if (sum > max_ext) begin
            pos_o = max_i;
        end else begin
            pos_o = sum[9:0];
        end
    end

endmodule

// File: rtl/ps2_pos_funcmod.sv
// Turns validated PS/2 mouse packets into a clamped cursor position, button
// levels and press pulses, with a one-deep newest-wins pending packet slot.
module ps2_pos_funcmod
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned XMAX  = 639,
    parameter int unsigned YMAX  = 479,
    parameter int unsigned XINIT = 320,
    parameter int unsigned YINIT = 240
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        iTrig,
    input  logic [23:0] iData,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic [2:0]  oBtn,
    output logic [2:0]  oClick,
    output logic        oTrig,
    output logic        oErr
);

    localparam logic [9:0] XMAX_L  = 10'(XMAX);
    localparam logic [9:0] YMAX_L  = 10'(YMAX);
    localparam logic [9:0] XINIT_L = 10'(XINIT);
    localparam logic [9:0] YINIT_L = 10'(YINIT);

    state_e      state_q, state_d;
    logic [23:0] work_q, work_d;
    logic [23:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [2:0]  btn_q, btn_d;
    logic [2:0]  click_q, click_d;
    logic        trig_q, trig_d;
    logic        err_q, err_d;
    logic [9:0]  x_next, y_next;

    ps2_axis_clamp #(.SUBTRACT(1'b0)) u_clamp_x (
        .pos_i   (x_q),
        .delta_i (x_delta(work_q)),
        .max_i   (XMAX_L),
        .pos_o   (x_next)
    );

    // Y is screen-down positive while the mouse reports up-positive.
    ps2_axis_clamp #(.SUBTRACT(1'b1)) u_clamp_y (
        .pos_i   (y_q),
        .delta_i (y_delta(work_q)),
        .max_i   (YMAX_L),
        .pos_o   (y_next)
    );

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        x_d        = x_q;
        y_d        = y_q;
        btn_d      = btn_q;
        click_d    = '0;
        trig_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    work_d     = pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = CHECK;
                end else if (iTrig) begin
                    work_d  = iData;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!work_q[ST_ONE]) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = ADD_X;
                end
            end
            ADD_X: begin
                x_d     = x_next;
                state_d = ADD_Y;
            end
            // Button/pulse registers load on entry to DONE so oTrig, oBtn,
            // oClick and the final oY are all visible during the DONE cycle.
            ADD_Y: begin
                y_d     = y_next;
                btn_d   = work_q[ST_M:ST_L];
                click_d = work_q[ST_M:ST_L] & ~btn_q;
                trig_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (pend_vld_q) begin
                    work_d     = pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = CHECK;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A trigger not taken directly into the work register goes to the
        // pending slot, overriding any consume in the same cycle.
        if (iTrig && !(state_q == IDLE && !pend_vld_q)) begin
            pend_d     = iData;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            work_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            x_q        <= XINIT_L;
            y_q        <= YINIT_L;
            btn_q      <= '0;
            click_q    <= '0;
            trig_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            x_q        <= x_d;
            y_q        <= y_d;
            btn_q      <= btn_d;
            click_q    <= click_d;
            trig_q     <= trig_d;
            err_q      <= err_d;
        end
    end

    assign oX     = x_q;
    assign oY     = y_q;
    assign oBtn   = btn_q;
    assign oClick = click_q;
    assign oTrig  = trig_q;
    assign oErr   = err_q;

endmodule

// File: tb/tb_ps2_pos_funcmod.sv
// Directed self-checking bench for ps2_pos_funcmod with hand-computed expectations.
module tb_ps2_pos_funcmod;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        iTrig = 1'b0;
    logic [23:0] iData = '0;
    logic [9:0]  oX, oY;
    logic [2:0]  oBtn, oClick;
    logic        oTrig, oErr;

    int n_cmp = 0;
    int n_err = 0;

    int         trigs, errs, clicks, lat;
    logic [9:0] cx, cy;
    logic [2:0] cbtn, cclk;

    ps2_pos_funcmod #(
        .XMAX  (639),
        .YMAX  (479),
        .XINIT (320),
        .YINIT (240)
    ) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .iTrig  (iTrig),
        .iData  (iData),
        .oX     (oX),
        .oY     (oY),
        .oBtn   (oBtn),
        .oClick (oClick),
        .oTrig  (oTrig),
        .oErr   (oErr)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge CLOCK);
        #1 RESET = 1'b0;
        iTrig = 1'b0;
        @(posedge CLOCK);
        @(posedge CLOCK);
        #1 RESET = 1'b1;
    endtask

    task automatic send(input logic [23:0] d);
        @(posedge CLOCK);
        #1 iTrig = 1'b1;
        iData = d;
        @(posedge CLOCK);
        #1 iTrig = 1'b0;
    endtask

    // Observe n cycles; lat is the cycle index (iTrig cycle = 0) of the first oTrig.
    task automatic watch(input int n);
        trigs = 0; errs = 0; clicks = 0; lat = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge CLOCK);
            if (oClick != 3'b000) clicks++;
            if (oErr) errs++;
            if (oTrig) begin
                trigs++;
                if (lat == 0) begin
                    lat  = k;
                    cx   = oX;
                    cy   = oY;
                    cbtn = oBtn;
                    cclk = oClick;
                end
            end
        end
    endtask

    initial begin
        #2;
        @(negedge CLOCK);
        chk("rst_x",     oX, 320);
        chk("rst_y",     oY, 240);
        chk("rst_btn",   oBtn, 0);
        chk("rst_click", oClick, 0);
        chk("rst_trig",  oTrig, 0);
        chk("rst_err",   oErr, 0);
        @(posedge CLOCK);
        #1 RESET = 1'b1;

        // Basic move: dX=+10, dY=+5
        send(24'h050A08); watch(10);
        chk("mv_lat", lat, 4);
        chk("mv_trigs", trigs, 1);
        chk("mv_x", cx, 330);
        chk("mv_y", cy, 235);
        chk("mv_btn", cbtn, 0);

        // dX=-128 three times, clamping at 0
        do_reset();
        send(24'h008019); watch(10);
        chk("neg1_x", cx, 192); chk("neg1_y", cy, 240); chk("neg1_clk", cclk, 3'b001);
        send(24'h008019); watch(10);
        chk("neg2_x", cx, 64);  chk("neg2_clk", cclk, 3'b000); chk("neg2_btn", cbtn, 3'b001);
        send(24'h008019); watch(10);
        chk("neg3_x", cx, 0);   chk("neg3_y", cy, 240);

        // Clicks, with a rejected packet between presses
        do_reset();
        send(24'h000009); watch(10);
        chk("clk1_clk", cclk, 3'b001); chk("clk1_btn", cbtn, 3'b001); chk("clk1_n", clicks, 1);
        send(24'h050500); watch(10);
        chk("err_n", errs, 1); chk("err_trigs", trigs, 0);
        chk("err_x", oX, 320); chk("err_y", oY, 240); chk("err_btn", oBtn, 3'b001);
        send(24'h000009); watch(10);
        chk("clk2_clk", cclk, 3'b000); chk("clk2_btn", cbtn, 3'b001); chk("clk2_n", clicks, 0);
        send(24'h000008); watch(10);
        chk("clk3_btn", cbtn, 3'b000); chk("clk3_n", clicks, 0);

        // Clamp edges and overflow suppression
        do_reset();
        send(24'h00FF08); watch(10); chk("xmax1", cx, 575);
        send(24'h00FF08); watch(10); chk("xmax2", cx, 639);
        send(24'h000028); watch(10); chk("ymax", cy, 479);
        send(24'hFF0008); watch(10); chk("ymin1", cy, 224);
        send(24'hFF0008); watch(10); chk("ymin2", cy, 0);
        send(24'h007F48); watch(10); chk("xovf", cx, 639);
        send(24'h7F0088); watch(10); chk("yovf", cy, 0);

        // A, B, C back-to-back: B overwritten by C
        do_reset();
        @(posedge CLOCK);
        #1 iTrig = 1'b1; iData = 24'h000A08;
        @(posedge CLOCK);
        #1 iData = 24'h001408;
        @(posedge CLOCK);
        #1 iData = 24'h001E08;
        @(posedge CLOCK);
        #1 iTrig = 1'b0;
        watch(20);
        chk("abc_trigs", trigs, 2);
        chk("abc_x", oX, 360);

        // Reset while in ADD_X with a pending packet queued
        send(24'h000A08);
        #0 iTrig = 1'b1; iData = 24'h001408;
        @(posedge CLOCK);
        #1 iTrig = 1'b0;
        RESET = 1'b0;
        #2;
        chk("mid_rst_x", oX, 320);
        chk("mid_rst_y", oY, 240);
        @(posedge CLOCK);
        @(posedge CLOCK);
        #1 RESET = 1'b1;
        watch(12);
        chk("mid_trigs", trigs, 0);
        chk("mid_x", oX, 320);
        send(24'h050A08); watch(10);
        chk("post_lat", lat, 4);
        chk("post_x", cx, 330);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
